// File: rtl/peripheral_bus_decoder_if.sv
// rtl/peripheral_bus_decoder_if.sv - processor peripheral port and slave channel signals of the decoder
interface peripheral_bus_decoder_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                             read;
  logic                             write;
  logic [ADDR_WIDTH-1:0]            address;
  logic [DATA_WIDTH-1:0]            write_data;
  logic [DATA_WIDTH-1:0]            read_data;
  logic                             response;
  logic                             error;
  logic [NUM_SLAVES-1:0]            s_read;
  logic [NUM_SLAVES-1:0]            s_write;
  logic [ADDR_WIDTH-1:0]            s_address;
  logic [DATA_WIDTH-1:0]            s_write_data;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_read_data;
  logic [NUM_SLAVES-1:0]            s_response;

  // Environment view: the processor drives requests, the devices drive completions.
  modport master (
    output read, write, address, write_data, s_read_data, s_response,
    input  read_data, response, error, s_read, s_write, s_address, s_write_data
  );

  // Decoder view.
  modport slave (
    input  read, write, address, write_data, s_read_data, s_response,
    output read_data, response, error, s_read, s_write, s_address, s_write_data
  );
endinterface

// File: rtl/peripheral_bus_decoder.sv
// rtl/peripheral_bus_decoder.sv - address-window decoder routing one peripheral port to NUM_SLAVES devices; optional PERIPHERAL_BUS_TIMEOUT_EN adds an ACCESS timeout
module peripheral_bus_decoder #(
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS   = ADDR_WIDTH'(32'h00001000),
  parameter int                    SPAN_BITS      = 8,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = DATA_WIDTH'(32'hDEADBEEF)
) (
  input logic                     clk,
  input logic                     rst,
  peripheral_bus_decoder_if.slave bus
);
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  // Reject parameter values outside the supported ranges at elaboration.
  generate
    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
      $error("NUM_SLAVES must be 1..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be 1..65535");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND, RELEASE} state_t;

  state_t                state_q;
  state_t                state_d;

  logic                  op_write_q;
  logic [IDX_W-1:0]      idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  error_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] win_idx;
  logic                  req_any;
  logic                  decode_miss;

  logic                  sel_resp;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timeout_hit;

  logic                  take_req;
  logic                  finish_ok;
  logic                  finish_err;
  logic [NUM_SLAVES-1:0] s_read_d;
  logic [NUM_SLAVES-1:0] s_write_d;

  // Window index uses wrapping unsigned arithmetic; addresses below the base
  // are caught by the explicit compare, not by the wrapped index.
  assign offset      = bus.address - BASE_ADDRESS;
  assign win_idx     = offset >> SPAN_BITS;
  assign req_any     = bus.read | bus.write;
  assign decode_miss = (bus.address < BASE_ADDRESS)
                     | (win_idx >= ADDR_WIDTH'(NUM_SLAVES))
                     | (bus.read & bus.write);

  // Select completion and read data of the latched slave channel only.
  always_comb begin
    sel_resp  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_resp  = bus.s_response[i];
        sel_rdata = bus.s_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  // Count cycles spent in ACCESS; cleared in every other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ACCESS) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  // Terminal count lands on the last ACCESS cycle so the strobe lasts TIMEOUT_CYCLES.
  assign timeout_hit = (state_q == ACCESS) && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, request/result controls and slave strobes.
  always_comb begin
    state_d    = state_q;
    take_req   = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    s_read_d   = '0;
    s_write_d  = '0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          take_req = 1'b1;
          if (decode_miss) begin
            finish_err = 1'b1;
            state_d    = RESPOND;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            s_read_d[i]  = ~op_write_q;
            s_write_d[i] = op_write_q;
          end
        end
        // A slave completion in the terminal-count cycle takes priority.
        if (sel_resp) begin
          finish_ok = 1'b1;
          state_d   = RESPOND;
        end else if (timeout_hit) begin
          finish_err = 1'b1;
          state_d    = RESPOND;
        end
      end
      RESPOND: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!req_any) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the accepted request and record the result shown during RESPOND.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_write_q <= 1'b0;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      if (take_req) begin
        op_write_q <= bus.write;
        idx_q      <= win_idx[IDX_W-1:0];
        addr_q     <= bus.address;
        wdata_q    <= bus.write_data;
      end
      if (finish_err) begin
        rdata_q <= ERROR_DATA;
        error_q <= 1'b1;
      end else if (finish_ok) begin
        rdata_q <= op_write_q ? '0 : sel_rdata;
        error_q <= 1'b0;
      end
    end
  end

  assign bus.response     = (state_q == RESPOND);
  assign bus.error        = error_q;
  assign bus.read_data    = rdata_q;
  assign bus.s_read       = s_read_d;
  assign bus.s_write      = s_write_d;
  assign bus.s_address    = addr_q;
  assign bus.s_write_data = wdata_q;
endmodule

// File: tb/tb_peripheral_bus_decoder.sv
// tb/tb_peripheral_bus_decoder.sv - randomized self-checking bench for peripheral_bus_decoder against a transaction-level model
module tb_peripheral_bus_decoder;
  localparam int          NS   = 4;
  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          TMO  = 8;
  localparam longint      BASE = 64'h1000;
  localparam longint      SPAN = 256;
  localparam logic [31:0] EDAT = 32'hDEADBEEF;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  peripheral_bus_decoder_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  peripheral_bus_decoder #(
    .NUM_SLAVES    (NS),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .BASE_ADDRESS  (32'h00001000),
    .SPAN_BITS     (8),
    .TIMEOUT_CYCLES(TMO),
    .ERROR_DATA    (32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One master transaction plus the expected slave behaviour.
  // dly: cycles after the first strobe cycle before the slave answers (-1 = never).
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] sdata,
                            input int dly, input int hold);
    longint      a;
    bit          miss;
    bit          timed_out;
    int          idx;
    int          lat;
    logic [3:0]  onehot;
    logic [3:0]  noise;
    bit          exp_err;
    logic [31:0] exp_rdata;

    a    = longint'(addr);
    miss = (rd && wr) || (a < BASE) || (((a - BASE) / SPAN) >= NS);
    idx  = miss ? 0 : int'((a - BASE) / SPAN);
    onehot = miss ? 4'b0000 : 4'(1 << idx);
    timed_out = 1'b0;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    if (!miss && (dly < 0 || dly >= TMO)) timed_out = 1'b1;
`endif
    if (miss)           lat = 1;
    else if (timed_out) lat = TMO + 1;
    else                lat = dly + 2;
    exp_err   = miss || timed_out;
    exp_rdata = exp_err ? EDAT : (rd ? sdata : 32'h0);

    bus.read       = rd;
    bus.write      = wr;
    bus.address    = addr;
    bus.write_data = wdata;

    for (int cyc = 1; cyc <= lat; cyc++) begin
      step();
      if (cyc < lat) begin
        check_eq("strobe_rd", {28'h0, bus.s_read},  (rd && !miss) ? {28'h0, onehot} : 32'h0);
        check_eq("strobe_wr", {28'h0, bus.s_write}, (wr && !miss) ? {28'h0, onehot} : 32'h0);
        check_eq("early_resp", {31'h0, bus.response}, 32'h0);
        if (cyc == 1 && !miss) begin
          check_eq("s_address", bus.s_address, addr);
          if (wr) check_eq("s_write_data", bus.s_write_data, wdata);
        end
        bus.s_read_data = {$urandom, $urandom, $urandom, $urandom};
        if (!miss) bus.s_read_data[idx*32 +: 32] = sdata;
        noise = 4'($urandom) & ~onehot;
        bus.s_response = (!miss && dly >= 0 && (cyc - 1) == dly) ? (noise | onehot) : noise;
      end else begin
        check_eq("resp", {31'h0, bus.response}, 32'h1);
        check_eq("resp_error", {31'h0, bus.error}, {31'h0, exp_err});
        check_eq("resp_data", bus.read_data, exp_rdata);
        check_eq("resp_strobes", {24'h0, bus.s_read, bus.s_write}, 32'h0);
        bus.s_response = '0;
      end
    end

    for (int h = 0; h < hold; h++) begin
      step();
      check_eq("held_no_resp", {31'h0, bus.response}, 32'h0);
      check_eq("held_no_strobe", {24'h0, bus.s_read, bus.s_write}, 32'h0);
      check_eq("held_data", bus.read_data, exp_rdata);
      check_eq("held_error", {31'h0, bus.error}, {31'h0, exp_err});
    end

    bus.read  = 1'b0;
    bus.write = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check_eq("gap_quiet", {23'h0, bus.response, bus.s_read, bus.s_write}, 32'h0);
    end
  endtask

  initial begin
    n_total          = 0;
    n_bad            = 0;
    rst              = 1'b1;
    bus.read         = 1'b0;
    bus.write        = 1'b0;
    bus.address      = '0;
    bus.write_data   = '0;
    bus.s_read_data  = '0;
    bus.s_response   = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    check_eq("rst_response", {31'h0, bus.response}, 32'h0);
    check_eq("rst_error", {31'h0, bus.error}, 32'h0);
    check_eq("rst_strobes", {24'h0, bus.s_read, bus.s_write}, 32'h0);
    check_eq("rst_read_data", bus.read_data, 32'h0);
    check_eq("rst_s_address", bus.s_address, 32'h0);
    check_eq("rst_s_write_data", bus.s_write_data, 32'h0);

    run_access(1, 0, 32'h00001104, 32'h0, 32'hCAFE0001, 1, 0);
    run_access(0, 1, 32'h00001000, 32'h000000A5, 32'h0, 0, 0);
    run_access(1, 0, 32'h00001400, 32'h0, 32'h12345678, 0, 1);
    run_access(1, 0, 32'h00000FFC, 32'h0, 32'h0, 0, 0);
    run_access(1, 1, 32'h00001200, 32'h55, 32'h0, 0, 0);
    run_access(1, 0, 32'h000013FC, 32'h0, 32'h0BADF00D, 3, 0);
    run_access(1, 0, 32'h00001200, 32'h0, 32'h11112222, 2, 5);
    run_access(1, 0, 32'h00001208, 32'h0, 32'h33334444, TMO - 1, 1);
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    run_access(1, 0, 32'h00001210, 32'h0, 32'h0, -1, 1);
`endif

    bus.read    = 1'b1;
    bus.address = 32'h00001208;
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq("pre_rst_strobe", {28'h0, bus.s_read}, 32'h4);
    end
    rst      = 1'b1;
    bus.read = 1'b0;
    step();
    check_eq("mid_rst_strobes", {24'h0, bus.s_read, bus.s_write}, 32'h0);
    check_eq("mid_rst_response", {31'h0, bus.response}, 32'h0);
    check_eq("mid_rst_read_data", bus.read_data, 32'h0);
    check_eq("mid_rst_error", {31'h0, bus.error}, 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("post_rst_quiet", {23'h0, bus.response, bus.s_read, bus.s_write}, 32'h0);
    end
    run_access(1, 0, 32'h00001300, 32'h0, 32'h9ABCDEF0, 1, 0);

    for (int t = 0; t < 40; t++) begin
      int          kind;
      logic [31:0] addr;
      kind = $urandom_range(0, 9);
      addr = 32'h00000F00 + ($urandom_range(0, 32'h600) & 32'hFFFF_FFFC);
      run_access(kind <= 5, (kind == 0) || (kind >= 6), addr, $urandom, $urandom,
                 $urandom_range(0, 4), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/peripheral_bus_decoder.md
# peripheral_bus_decoder

Parametrised peripheral interconnect between the processor's single peripheral port and up to `NUM_SLAVES` memory-mapped devices such as LEDs, GPIO and UART. It sits in the SoC top where the processor's peripheral port currently wires straight to one device. It decodes each access into a fixed-size address window and forwards it to exactly one slave. It reports an error on decode misses and, optionally, on slave timeouts.

## Interface
- `NUM_SLAVES`, 4: number of slave channels, 1..16.
- `DATA_WIDTH`, 32: data bus width.
- `ADDR_WIDTH`, 32: address bus width.
- `BASE_ADDRESS`, 32'h00001000: first byte address of slave 0.
- `SPAN_BITS`, 8: log2 window size per slave; slave i owns `BASE_ADDRESS + i*2^SPAN_BITS` up to the next window.
- `TIMEOUT_CYCLES`, 255: ACCESS cycles before abort (macro-enabled only), 1..65535.
- `ERROR_DATA`, 32'hDEADBEEF: `read_data` value returned with `error`.
- Clocking/reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `read`  in  1  master read request (level).
- `write`  in  1  master write request (level).
- `address`  in  ADDR_WIDTH  master byte address.
- `write_data`  in  DATA_WIDTH  master write data.
- `read_data`  out  DATA_WIDTH  registered read data, valid while `response`=1.
- `response`  out  1  one-cycle completion pulse.
- `error`  out  1  qualifies `response`: access failed.
- `s_read`  out  NUM_SLAVES  per-slave read strobe.
- `s_write`  out  NUM_SLAVES  per-slave write strobe.
- `s_address`  out  ADDR_WIDTH  latched address, shared by all slaves.
- `s_write_data`  out  DATA_WIDTH  latched write data, shared by all slaves.
- `s_read_data`  in  NUM_SLAVES*DATA_WIDTH  slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_response`  in  NUM_SLAVES  per-slave completion.

## Operation
- FSM states: IDLE, ACCESS, RESPOND, RELEASE. Reset value is IDLE.
- Reset values:
  - `response`, `error`, `s_read`, `s_write` = 0.
  - `read_data`, `s_address`, `s_write_data` = 0.
  - Timeout counter = 0.
- IDLE: on `read` or `write` high:
  - Latch `address`, `write_data` and the operation.
  - Compute `idx = (address - BASE_ADDRESS) >> SPAN_BITS`, full ADDR_WIDTH unsigned arithmetic.
  - Miss (address < BASE_ADDRESS or idx ≥ NUM_SLAVES) → RESPOND with error.
  - Hit → ACCESS.
- `read` and `write` both high in IDLE → RESPOND with error; no slave is touched.
- ACCESS:
  - `s_read[idx]` or `s_write[idx]` is held high; all other strobes stay low.
  - On `s_response[idx]`: capture slave data (reads) → RESPOND, error=0.
  - `s_response` from any non-selected slave is ignored.
- RESPOND:
  - `response`=1 for exactly one cycle; all strobes are low.
  - `read_data` = captured data on a successful read, `ERROR_DATA` on error, 0 on a successful write.
  - Next state is RELEASE.
- RELEASE: wait until `read` and `write` are both low, then IDLE. A held request is never re-executed.
- `read_data` and `error` hold their values until the next RESPOND.

## Timing
- Request sampled at edge T0 → strobe high from T1.
- Slave responds in cycle Tk (k≥1) → `response` high in cycle Tk+1.
- Minimum latency is 2 cycles, with a same-cycle slave response at T1.
- Decode miss or double request → `response` in cycle T1.
- Timeout: the counter increments every ACCESS cycle. When it reaches `TIMEOUT_CYCLES`, the FSM moves to RESPOND with error and the strobe drops.
- If the slave response and timeout terminal count land in the same cycle, the slave response wins (error=0).
- `rst` high at any edge:
  - All outputs return to reset values at that edge.
  - An in-flight access is abandoned; no `response` is issued.

## Configuration
- `PERIPHERAL_BUS_TIMEOUT_EN` defined: the timeout counter and abort path are compiled in, with behaviour as above.
- `PERIPHERAL_BUS_TIMEOUT_EN` undefined:
  - No counter exists; ACCESS waits indefinitely for `s_response[idx]`.
  - `error` is raised only for decode misses and double requests.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- Read at 32'h00001104 with slave 1 responding with 32'hCAFE0001 one cycle after its strobe:
  - Required: only `s_read[1]`=1.
  - Required: `response`=1, `error`=0, `read_data`=32'hCAFE0001 in cycle T3.
- Write 32'h000000A5 to 32'h00001000 with slave 0 responding combinationally:
  - Required: `s_write[0]` high for exactly one cycle, `s_write_data`=32'hA5.
  - Required: `response` in cycle T2.
- Read at 32'h00001400 (idx 4, beyond 4 slaves):
  - Required: no strobe; `response`=1, `error`=1, `read_data`=32'hDEADBEEF in cycle T1.
- Read to slave 2 that never responds, macro defined, TIMEOUT_CYCLES=8:
  - Required: `s_read[2]` high for 8 cycles, then `response`+`error` with `read_data`=32'hDEADBEEF.
- Master holds `read` for 5 cycles after `response`:
  - Required: exactly one slave access.
  - Required: a new access starts only after `read` drops and is reasserted.
- `rst` asserted during ACCESS:
  - Required: strobes low and state IDLE at that edge, no `response`.
  - Required: the next request completes normally.
